keypad_scanner: RTL and testbench

//  Input-side counterpart of the multiplexed 7-seg display path: scans a 4x4 matrix keypad
//  (columns driven active-low one at a time, rows read back), debounces, and hands one key

---
 rtl/keypad_pkg.sv | 52 +++++
 rtl/keypad_col_scan.sv | 99 +++++++++
 rtl/keypad_scanner.sv | 209 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner: FSM state codes,
// per-scan result encoding, key-code constants and the row/column to key-code lookup.
package keypad_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_res_e;

  typedef struct packed {
    scan_res_e  res;
    logic [3:0] code;
  } scan_result_t;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_C     = 4'd12;
  localparam logic [3:0] KEY_D     = 4'd13;
  localparam logic [3:0] KEY_STAR  = 4'd14;
  localparam logic [3:0] KEY_HASH  = 4'd15;

  // Board layout: row0 "1 2 3 A", row1 "4 5 6 B", row2 "7 8 9 C", row3 "* 0 # D".
  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_PLUS;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_MINUS;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column driver and row sampler: drives one column low per SCAN_DIV-cycle window,
// synchronizes the rows, and reports a NONE/SINGLE/MULTI result with a strobe after column 3.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   row,
  output logic [3:0]   col,
  output logic         scan_done,
  output scan_result_t scan_result
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       hits_q, hits_d;   // low rows seen this scan, saturating at 2
  logic [3:0]       code_q, code_d;
  logic             done_q, done_d;
  scan_result_t     result_q, result_d;

  logic [3:0] row_low;
  logic [2:0] n_low;
  logic [1:0] low_row_idx;
  logic [2:0] total;
  logic [3:0] code_new;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
    div_d      = div_q + DIV_W'(1);
    col_idx_d  = col_idx_q;
    hits_d     = hits_q;
    code_d     = code_q;
    done_d     = 1'b0;
    result_d   = result_q;

    row_low     = ~row_sync_q;
    n_low       = 3'($countones(row_low));
    low_row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_low[i]) low_row_idx = 2'(i);
    end
    total    = {1'b0, hits_q} + n_low;
    code_new = (n_low == 3'd1) ? key_lookup(low_row_idx, col_idx_q) : code_q;

    if (div_q == DIV_LAST) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (col_idx_q == 2'd3) begin
        done_d        = 1'b1;
        result_d.code = code_new;
        if (total == 3'd0)      result_d.res = SCAN_NONE;
        else if (total == 3'd1) result_d.res = SCAN_SINGLE;
        else                    result_d.res = SCAN_MULTI;
        hits_d = '0;
        code_d = '0;
      end else begin
        hits_d = (total > 3'd2) ? 2'd2 : total[1:0];
        code_d = code_new;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_idx_q  <= '0;
      hits_q     <= '0;
      code_q     <= '0;
      done_q     <= 1'b0;
      result_q   <= '{res: SCAN_NONE, code: 4'd0};
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      hits_q     <= hits_d;
      code_q     <= code_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign col         = ~(4'b0001 << col_idx_q);
  assign scan_done   = done_q;
  assign scan_result = result_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with scan-level debounce and a valid/ready key-event output.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_DELAY   = 250,
  parameter int REPEAT_RATE    = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       key_overrun
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_SCANS);

  logic         scan_done;
  scan_result_t scan_result;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .scan_done   (scan_done),
    .scan_result (scan_result)
  );

  logic [1:0] state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_down_q, key_down_d;
  logic       overrun_q, overrun_d;

  logic       emit;
  logic       is_none;
  logic       is_cand;
  logic [7:0] cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_first_q, rpt_first_d;   // still waiting for the first repeat
  logic [RPT_W-1:0] rpt_inc;
  logic [RPT_W-1:0] rpt_target;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    overrun_d   = 1'b0;
    emit        = 1'b0;
    is_none     = (scan_result.res == SCAN_NONE);
    is_cand     = (scan_result.res == SCAN_SINGLE) && (scan_result.code == cand_q);
    cnt_inc     = cnt_q + 8'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_inc     = rpt_q + RPT_W'(1);
    rpt_target  = rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
`endif

    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_result.res == SCAN_SINGLE) begin
            cand_d = scan_result.code;
            if (DEBOUNCE_SCANS == 1) begin
              emit       = 1'b1;
              key_down_d = 1'b1;
              state_d    = ST_HELD;
              cnt_d      = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = 8'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!is_cand) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_LAST) begin
            emit       = 1'b1;
            key_down_d = 1'b1;
            state_d    = ST_HELD;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HELD: begin
          if (is_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d    = ST_IDLE;
              key_down_d = 1'b0;
              cnt_d      = '0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = 8'd1;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (is_cand) begin
            if (rpt_inc == rpt_target) begin
              emit        = 1'b1;
              rpt_d       = '0;
              rpt_first_d = 1'b0;
            end else begin
              rpt_d = rpt_inc;
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (!is_none) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_d    = ST_IDLE;
            key_down_d = 1'b0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    if (state_d != ST_HELD) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end
`endif

    // A pending event is retired by a transfer; a new one may load on that same edge.
    key_valid_d = key_valid_q & ~key_ready;
    if (emit) begin
      if (!key_valid_q || key_ready) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign key_overrun = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: ideal keypad matrix model, scan-aligned directed and random
// key patterns, and a scan-level reference model of debounce, handshake and auto-repeat.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int RD  = 4;
  localparam int RR  = 2;
  localparam int SCAN_CYCLES = 4 * SD;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004, KA = 16'h0008;
  localparam logic [15:0] K5 = 16'h0020, K9 = 16'h0400, K0 = 16'h2000, KHASH = 16'h4000;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;
  logic       key_overrun;

  logic [15:0] pressed;   // bit r*4+c set = key at row r, column c held

  keypad_scanner #(
    .SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_down    (key_down),
    .key_overrun (key_overrun)
  );

  always #5 clock = ~clock;

  // A row reads low when any pressed key in it sits on the column currently driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  int vectors    = 0;
  int miscompares = 0;

  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];
  int         got_overruns = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (key_valid && key_ready) got_q.push_back(key_code);
      if (key_overrun) got_overruns++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (one call per complete scan) ----------------
  int layout[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  bit m_down;
  int m_run;        // consecutive qualifying scans toward press or release
  int m_cand;
  int m_held;       // scans of the candidate seen while settled in the held phase
  bit m_valid;
  int m_code;
  int m_overruns;

  function automatic int classify(input logic [15:0] m);
    if ($countones(m) == 0) return -1;
    if ($countones(m) > 1) return -2;
    for (int i = 0; i < 16; i++) if (m[i]) return layout[i];
    return -2;
  endfunction

  task automatic model_reset();
    m_down = 0; m_run = 0; m_cand = 0; m_held = 0;
    m_valid = 0; m_code = 0; m_overruns = 0;
  endtask

  task automatic model_emit(input int code);
    if (!m_valid || key_ready) begin
      if (key_ready) exp_q.push_back(4'(code));
      else begin m_valid = 1; m_code = code; end
    end else m_overruns++;
  endtask

  task automatic model_accept();
    m_down = 1; m_run = 0; m_held = 0;
    model_emit(m_cand);
  endtask

  task automatic model_scan(input int r);
    if (!m_down) begin
      if (m_run == 0) begin
        if (r >= 0) begin
          m_cand = r; m_run = 1;
          if (m_run >= DEB) model_accept();
        end
      end else if (r == m_cand) begin
        m_run++;
        if (m_run >= DEB) model_accept();
      end else m_run = 0;
    end else if (r == -1) begin
      m_run++; m_held = 0;
      if (m_run >= DEB) begin m_down = 0; m_run = 0; end
    end else begin
      if (m_run == 0 && r == m_cand && AUTOREPEAT) begin
        m_held++;
        if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) model_emit(m_cand);
      end
      m_run = 0;
    end
  endtask

  task automatic set_ready(input logic v);
    key_ready = v;
    if (v && m_valid) begin exp_q.push_back(4'(m_code)); m_valid = 0; end
  endtask

  // One full scan with a fixed key pattern; checks the effect of the previous scan on the way.
  task automatic do_scan(input logic [15:0] mask);
    pressed = mask;
    repeat (2) @(posedge clock); #1;
    check("key_down", 32'(key_down), 32'(m_down));
    check("col_first", 32'(col), 32'(4'b1110));
    repeat (7) @(posedge clock); #1;
    check("col_third", 32'(col), 32'(4'b1011));
    repeat (SCAN_CYCLES - 9) @(posedge clock); #1;
    model_scan(classify(mask));
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_code"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_overruns"}, 32'(got_overruns), 32'(m_overruns));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col"}, 32'(col), 32'(4'b1110));
    check({tag, "_key_code"}, 32'(key_code), 32'd0);
    check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_key_down"}, 32'(key_down), 32'd0);
    check({tag, "_key_overrun"}, 32'(key_overrun), 32'd0);
  endtask

  initial begin
    int n_seg;
    int exp_rep;
    logic [15:0] rmask;

    reset = 1'b1; key_ready = 1'b1; pressed = '0;
    model_reset();
    repeat (3) @(posedge clock); #1;
    check_reset_values("reset");
    @(negedge clock) reset = 1'b0;

    // Clean press of '5'.
    repeat (10) do_scan(K5);
    repeat (4) do_scan('0);
    compare_events("press_5");

    // '9' bouncing every scan never qualifies.
    for (int i = 0; i < 6; i++) do_scan(i[0] ? 16'h0000 : K9);
    repeat (4) do_scan('0);
    n_seg = got_q.size();
    check("bounce_9_events", 32'(n_seg), 32'd0);
    compare_events("bounce_9");

    // Two keys together are rejected; the remaining one then debounces.
    repeat (5) do_scan(K1 | KA);
    repeat (5) do_scan(K1);
    repeat (4) do_scan('0);
    compare_events("multi_then_1");

    // Consumer stalled: second event is dropped with a single overrun pulse.
    got_overruns = 0; m_overruns = 0;
    set_ready(1'b0);
    repeat (4) do_scan(K2);
    repeat (4) do_scan('0);
    repeat (4) do_scan(K3);
    repeat (4) do_scan('0);
    check("stall_valid", 32'(key_valid), 32'(m_valid));
    check("stall_code", 32'(key_code), 32'(m_code));
    check("stall_overrun", 32'(got_overruns), 32'(m_overruns));
    set_ready(1'b1);
    do_scan('0);
    compare_events("stall_release");
    check("after_transfer_valid", 32'(key_valid), 32'd0);

    // Reset while '#' is held; the key must re-debounce and report once more.
    got_overruns = 0; m_overruns = 0;
    repeat (5) do_scan(KHASH);
    compare_events("hash_before_reset");
    repeat (7) @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(posedge clock);
    model_reset();
    @(negedge clock) reset = 1'b0;
    repeat (5) do_scan(KHASH);
    repeat (4) do_scan('0);
    compare_events("hash_after_reset");

    // Long hold of '0': auto-repeat when enabled, a single event otherwise.
    got_overruns = 0; m_overruns = 0;
    repeat (12) do_scan(K0);
    repeat (4) do_scan('0);
    exp_rep = AUTOREPEAT ? 4 : 1;
    n_seg = got_q.size();
    check("hold_0_events", 32'(n_seg), 32'(exp_rep));
    compare_events("hold_0");

    // Random patterns with persistence so presses, holds and bounces all occur.
    rmask = '0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        6, 7:    rmask = '0;
        8:       rmask = 16'(1) << $urandom_range(0, 15);
        9:       rmask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: rmask = rmask;
      endcase
      do_scan(rmask);
    end
    repeat (4) do_scan('0);
    compare_events("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
